// File: rtl/vga_capture.sv
// vga_capture: measures VGA sync timing, locks onto a stable raster and writes
// one requested frame of active pixels into a linear frame buffer.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  pixel_in,
  input  logic        capture_req,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        locked,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total
);

  localparam logic [9:0]  H_FIRST   = 10'(H_BP);
  localparam logic [9:0]  H_LAST    = 10'(H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  V_FIRST   = 10'(V_BP);
  localparam logic [9:0]  V_LAST    = 10'(V_BP + V_ACTIVE - 1);
  localparam logic [9:0]  H_MIN     = 10'(H_BP + H_ACTIVE);
  localparam logic [9:0]  V_MIN     = 10'(V_BP + V_ACTIVE);
  localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] val);
    if (val == 10'd1023) begin
      return 10'd1023;
    end else begin
      return val + 10'd1;
    end
  endfunction

  logic        hs_r, vs_r, hs_d_r, vs_d_r;
  logic [2:0]  px_r;
  logic [9:0]  h_cnt_r, v_cnt_r, h_total_r, v_total_r;
  lock_state_t lock_state_r;
  cap_state_t  cap_state_r;
  logic [18:0] addr_cnt_r;
  logic        locked_r, busy_r, wr_en_r, frame_done_r, frame_err_r;
  logic [18:0] wr_addr_r;
  logic [2:0]  wr_data_r;

  logic        hs_edge_s, vs_edge_s, active_s, lock_loss_s;
  logic [9:0]  h_meas_s, v_meas_s, h_idx_s, v_idx_s, h_check_s;

  // Input synchroniser stage plus one-cycle history for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_r   <= 1'b0;
      vs_r   <= 1'b0;
      hs_d_r <= 1'b0;
      vs_d_r <= 1'b0;
      px_r   <= 3'd0;
    end else begin
      hs_r   <= hsync_in;
      vs_r   <= vsync_in;
      hs_d_r <= hs_r;
      vs_d_r <= vs_r;
      px_r   <= pixel_in;
    end
  end

  // Raster position of the registered sample and lock-loss detection.
  always_comb begin
    hs_edge_s = hs_r & ~hs_d_r;
    vs_edge_s = vs_r & ~vs_d_r;
    h_meas_s  = sat_inc(h_cnt_r);
    v_meas_s  = sat_inc(v_cnt_r);
    if (hs_edge_s) begin
      h_idx_s   = 10'd0;
      h_check_s = h_meas_s;
    end else begin
      h_idx_s   = h_meas_s;
      h_check_s = h_total_r;
    end
    if (vs_edge_s) begin
      v_idx_s = 10'd0;
    end else if (hs_edge_s) begin
      v_idx_s = v_meas_s;
    end else begin
      v_idx_s = v_cnt_r;
    end
    active_s = (h_idx_s >= H_FIRST) && (h_idx_s <= H_LAST) &&
               (v_idx_s >= V_FIRST) && (v_idx_s <= V_LAST);
    // Any line or frame whose length disagrees with the last measurement breaks lock.
    lock_loss_s = (lock_state_r == LOCKED) &&
                  ((hs_edge_s && (h_meas_s != h_total_r)) ||
                   (vs_edge_s && (v_meas_s != v_total_r)));
  end

  // Position counters and measured line/frame lengths.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_r   <= 10'd0;
      v_cnt_r   <= 10'd0;
      h_total_r <= 10'd0;
      v_total_r <= 10'd0;
    end else begin
      h_cnt_r <= h_idx_s;
      v_cnt_r <= v_idx_s;
      if (hs_edge_s) begin
        h_total_r <= h_meas_s;
      end
      if (vs_edge_s) begin
        v_total_r <= v_meas_s;
      end
    end
  end

  // Lock FSM with registered locked flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_state_r <= SEARCH;
      locked_r     <= 1'b0;
    end else begin
      case (lock_state_r)
        SEARCH: begin
          locked_r <= 1'b0;
          if (vs_edge_s) begin
            lock_state_r <= MEASURE;
          end
        end
        MEASURE: begin
          if (vs_edge_s && (h_check_s >= H_MIN) && (v_meas_s >= V_MIN)) begin
            lock_state_r <= LOCKED;
            locked_r     <= 1'b1;
          end else begin
            locked_r     <= 1'b0;
          end
        end
        LOCKED: begin
          if (lock_loss_s) begin
            lock_state_r <= SEARCH;
            locked_r     <= 1'b0;
          end else begin
            locked_r     <= 1'b1;
          end
        end
        default: begin
          lock_state_r <= SEARCH;
          locked_r     <= 1'b0;
        end
      endcase
    end
  end

  // Capture FSM: arms on request, writes one locked frame, aborts on lock loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_state_r  <= IDLE;
      addr_cnt_r   <= 19'd0;
      busy_r       <= 1'b0;
      wr_en_r      <= 1'b0;
      wr_addr_r    <= 19'd0;
      wr_data_r    <= 3'd0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      wr_en_r      <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (cap_state_r)
        IDLE: begin
          if (capture_req) begin
            cap_state_r <= ARMED;
            busy_r      <= 1'b1;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        ARMED: begin
          busy_r <= 1'b1;
          if (vs_edge_s && (lock_state_r == LOCKED) && !lock_loss_s) begin
            cap_state_r <= CAPTURE;
            addr_cnt_r  <= 19'd0;
          end
        end
        CAPTURE: begin
          if (lock_loss_s) begin
            cap_state_r <= IDLE;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b1;
          end else if (active_s) begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= addr_cnt_r;
            wr_data_r  <= px_r;
            addr_cnt_r <= addr_cnt_r + 19'd1;
            if (addr_cnt_r == ADDR_LAST) begin
              frame_done_r <= 1'b1;
              cap_state_r  <= IDLE;
              busy_r       <= 1'b0;
            end
          end
        end
        default: begin
          cap_state_r <= IDLE;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en      = wr_en_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;
  assign locked     = locked_r;
  assign h_total    = h_total_r;
  assign v_total    = v_total_r;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a reduced 14x8 raster with a frame-level
// reference model of lock acquisition, arming and capture.
module tb_vga_capture;

  localparam int HA = 8, HB = 3, VA = 4, VB = 2, HT = 14, VT = 8;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, capture_req = 1'b0;
  logic [2:0]  pixel_in = 3'd0;
  logic        wr_en, busy, frame_done, frame_err, locked;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;
  logic [9:0]  h_total, v_total;

  vga_capture #(.H_ACTIVE(HA), .H_BP(HB), .V_ACTIVE(VA), .V_BP(VB)) dut (
    .clk(clk), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_in(pixel_in), .capture_req(capture_req), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .locked(locked), .h_total(h_total), .v_total(v_total)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_errors = 0;

  // Frame-level reference model state.
  bit m_locked, m_armed, m_capt;
  int m_edges, m_htot, last_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and error pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      chk("write_was_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), mon_e.addr);
        chk("wr_data", 32'(wr_data), mon_e.data);
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("frame_done", 32'(frame_done), 32'(mon_e.done));
      end
    end else if (frame_done !== 1'b0) begin
      chk("frame_done_without_write", 32'(frame_done), 32'd0);
    end
    if (frame_err === 1'b1) begin
      chk("frame_err_was_expected", 32'(err_q.size() != 0), 32'd1);
      if (err_q.size() != 0) chk("frame_err_cycle", cyc, err_q.pop_front());
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic [2:0] px, input logic req);
    @(posedge clk);
    #1;
    hsync_in    = hs;
    vsync_in    = vs;
    pixel_in    = px;
    capture_req = req;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n     = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    pixel_in    = 3'd0;
    capture_req = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_h_total", 32'(h_total), 32'd0);
    chk("rst_v_total", 32'(v_total), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    m_locked = 1'b0;
    m_armed  = 1'b0;
    m_capt   = 1'b0;
    m_edges  = 0;
    m_htot   = HT;
    last_len = HT;
  endtask

  // mode: 0 random pixels, 1 pixel = x[2:0], 2 only (0,0) = 3'b101.
  task automatic run_frame(input int mode, input int req_line, input int req_pos,
                           input int short_line, input int reset_line);
    for (int line = 0; line < VT; line++) begin
      int len;
      len = (line == short_line) ? HT - 1 : HT;
      for (int pos = 0; pos < len; pos++) begin
        logic [2:0] px;
        bit req, act, was;
        int c, x, y, addr;
        if (line == reset_line && pos == 0) begin
          chk("pending_before_reset", exp_q.size(), 32'd0);
          apply_reset();
          return;
        end
        x = pos - HB;
        y = line - VB;
        act = (pos >= HB) && (pos < HB + HA) && (line >= VB) && (line < VB + VA);
        case (mode)
          1:       px = act ? x[2:0] : 3'($urandom);
          2:       px = (act && x == 0 && y == 0) ? 3'b101 : 3'b000;
          default: px = 3'($urandom_range(0, 7));
        endcase
        req = (line == req_line) && (pos == req_pos);
        drive(pos < len - 2, line < VT - 2, px, req);
        c = cyc;
        if (req && !m_armed && !m_capt) m_armed = 1'b1;
        if (pos == 0) begin
          if (m_locked && last_len != m_htot) begin
            m_locked = 1'b0;
            m_edges  = 0;
            if (m_capt) begin
              m_capt = 1'b0;
              err_q.push_back(c + 2);
            end
          end
          m_htot = last_len;
          if (line == 0) begin
            was = m_locked;
            if (!m_locked) begin
              m_edges++;
              if (m_edges >= 2) m_locked = 1'b1;
            end
            if (m_armed && was) begin
              m_armed = 1'b0;
              m_capt  = 1'b1;
            end
          end
        end
        if (m_capt && act) begin
          exp_t e;
          addr   = y * HA + x;
          e.addr = addr;
          e.data = int'(px);
          e.cyc  = c + 2;
          e.done = (addr == NPIX - 1);
          exp_q.push_back(e);
          if (addr == NPIX - 1) m_capt = 1'b0;
        end
        if (pos == 4) begin
          @(negedge clk);
          chk("locked", 32'(locked), 32'(m_locked));
          chk("busy", 32'(busy), 32'(m_armed || m_capt));
          if (m_locked && line == 1) begin
            chk("h_total", 32'(h_total), HT);
            chk("v_total", 32'(v_total), VT);
          end
        end
      end
      last_len = len;
    end
  endtask

  initial begin
    apply_reset();
    run_frame(0, -1, -1, -1, -1);  // first vsync edge: measure
    run_frame(0,  4,  6, -1, -1);  // lock here; request mid-frame
    run_frame(1, -1, -1, -1, -1);  // captured, x pattern
    run_frame(0, -1, -1, -1, -1);
    run_frame(0,  0,  1, -1, -1);  // request coincident with vsync edge: arm only
    run_frame(2,  3,  5, -1, -1);  // captured single pixel; request while busy ignored
    run_frame(0,  6,  2, -1, -1);  // not captured; arm for next
    run_frame(0, -1, -1,  3, -1);  // short line aborts capture
    run_frame(0,  2,  2, -1, -1);  // request while unlocked
    run_frame(0, -1, -1, -1, -1);  // relock, still armed
    run_frame(0,  7,  0, -1, -1);  // captured; re-arm after done
    run_frame(0, -1, -1, -1,  3);  // reset in the middle of capture
    run_frame(0,  2,  8, -1, -1);
    run_frame(0, -1, -1, -1, -1);
    run_frame(1, -1, -1, -1, -1);  // captured after reset recovery
    @(negedge clk);
    chk("writes_drained", exp_q.size(), 32'd0);
    chk("errors_drained", err_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
